mac_cfg_loader: RTL and testbench

- Serial configuration writer for a column of MAC blocks.
- Deserializes a bit stream into NUM_BLOCKS configuration words. Each word is the initial accumulate value concatenated with the config field, {init_val, conf}.
- Words are staged in a shadow bank, checked, and committed atomically to the parallel cfg bus that feeds each MAC block's cfg input.
- Unused stream bits bypass to a daisy-chain output so loaders can be cascaded.

---
 rtl/mac_cfg_loader_pkg.sv | 29 ++
 rtl/mac_cfg_loader_shifter.sv | 45 ++++
 rtl/mac_cfg_loader.sv | 140 ++++++++++++++
 tb/tb_mac_cfg_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_cfg_loader_pkg.sv
// Shared constants for the MAC configuration loader: config-field layout,
// mode encodings, default widths and the loader FSM state encoding.
package mac_cfg_loader_pkg;

  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_CONF_WIDTH = 3;

  localparam int MODE_LSB    = 0;
  localparam int MODE_MSB    = 1;
  localparam int ACC_SEL_BIT = 2;

  typedef enum logic [1:0] {
    MODE_SINGLE  = 2'b00,
    MODE_DUAL    = 2'b01,
    MODE_QUAD    = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_COMMIT = 2'b10
  } state_e;

  function automatic logic mode_illegal(input logic [1:0] mode);
    return mode == MODE_ILLEGAL;
  endfunction

endpackage

// File: rtl/mac_cfg_loader_shifter.sv
// Serial-to-parallel word assembler: shifts in qualified bits MSB first and
// flags the cycle in which the final bit of a word is being captured.
module mac_cfg_loader_shifter #(
  parameter int CFG_W = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic             word_done,
  output logic [CFG_W-1:0] word
);

  localparam int CNT_W = $clog2(CFG_W);

  // Only the newest CFG_W-1 bits are kept; the last bit arrives on din.
  logic [CFG_W-2:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  assign word_done = en && (bit_cnt_q == CNT_W'(CFG_W - 1));
  assign word      = {shreg_q, din};

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      bit_cnt_d = '0;
    end else if (en) begin
      shreg_d   = {shreg_q[CFG_W-3:0], din};
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/mac_cfg_loader.sv
// Serial configuration loader for a column of MAC blocks: stages words in a
// shadow bank, rejects illegal modes, and commits all blocks in one edge.
module mac_cfg_loader
  import mac_cfg_loader_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int CONF_WIDTH = DEF_CONF_WIDTH,
  parameter int NUM_BLOCKS = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        cfg_en,
  input  logic                                        cfg_in,
  output logic                                        cfg_out,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err,
  output logic                                        cfg_valid,
  output logic [NUM_BLOCKS*(ACC_WIDTH+CONF_WIDTH)-1:0] cfg_bus
);

  localparam int CFG_W = ACC_WIDTH + CONF_WIDTH;
  localparam int BUS_W = NUM_BLOCKS * CFG_W;
  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [CFG_W-1:0]   shadow_q [NUM_BLOCKS];
  logic [CFG_W-1:0]   shadow_d [NUM_BLOCKS];
  logic [BUS_W-1:0]   cfg_bus_q, cfg_bus_d;
  logic               cfg_out_q, cfg_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cfg_valid_q, cfg_valid_d;

  logic               load_clr;
  logic               shift_en;
  logic               word_done;
  logic [CFG_W-1:0]   word;
  logic               any_illegal;

  assign load_clr = (state_q == ST_IDLE) && start;
  assign shift_en = (state_q == ST_SHIFT) && cfg_en;

  mac_cfg_loader_shifter #(
    .CFG_W (CFG_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clr       (load_clr),
    .en        (shift_en),
    .din       (cfg_in),
    .word_done (word_done),
    .word      (word)
  );

  always_comb begin
    any_illegal = 1'b0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      any_illegal = any_illegal | mode_illegal(shadow_q[k][MODE_MSB:MODE_LSB]);
    end
  end

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    shadow_d    = shadow_q;
    cfg_bus_d   = cfg_bus_q;
    cfg_out_d   = cfg_out_q;
    err_d       = err_q;
    done_d      = 1'b0;
    cfg_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_en) cfg_out_d = cfg_in;
        if (start) begin
          state_d    = ST_SHIFT;
          word_idx_d = '0;
          err_d      = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (word_done) begin
          shadow_d[word_idx_q] = word;
          word_idx_d           = word_idx_q + IDX_W'(1);
          if (word_idx_q == IDX_W'(NUM_BLOCKS - 1)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // A rejected load leaves the active configuration untouched.
        done_d = 1'b1;
        if (any_illegal) begin
          err_d = 1'b1;
        end else begin
          for (int k = 0; k < NUM_BLOCKS; k++) begin
            cfg_bus_d[k*CFG_W +: CFG_W] = shadow_q[k];
          end
          cfg_valid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= '0;
      for (int k = 0; k < NUM_BLOCKS; k++) shadow_q[k] <= '0;
      cfg_bus_q   <= '0;
      cfg_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      shadow_q    <= shadow_d;
      cfg_bus_q   <= cfg_bus_d;
      cfg_out_q   <= cfg_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign cfg_out   = cfg_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_bus   = cfg_bus_q;

endmodule

// File: tb/tb_mac_cfg_loader.sv
// Self-checking bench for mac_cfg_loader: directed load table, bypass and
// reset sequences, and randomized loads checked against a word-level model.
module tb_mac_cfg_loader;
  import mac_cfg_loader_pkg::*;

  localparam int ACC_W = 32;
  localparam int CONF_W = 3;
  localparam int NB = 4;
  localparam int CFG_W = ACC_W + CONF_W;
  localparam int BUS_W = NB * CFG_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cfg_en = 1'b0;
  logic cfg_in = 1'b0;
  logic cfg_out, busy, done, err, cfg_valid;
  logic [BUS_W-1:0] cfg_bus;

  int checks = 0;
  int failures = 0;

  logic [BUS_W-1:0] model_bus = '0;
  logic             model_err = 1'b0;
  logic             exp_cfg_out = 1'b0;

  mac_cfg_loader #(
    .ACC_WIDTH  (ACC_W),
    .CONF_WIDTH (CONF_W),
    .NUM_BLOCKS (NB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_en    (cfg_en),
    .cfg_in    (cfg_in),
    .cfg_out   (cfg_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cfg_valid (cfg_valid),
    .cfg_bus   (cfg_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CFG_W-1:0] mk(input logic [31:0] init, input logic acc, input mode_e mode);
    logic [CONF_W-1:0] conf;
    conf = '0;
    conf[ACC_SEL_BIT] = acc;
    conf[MODE_MSB:MODE_LSB] = mode;
    return {init, conf};
  endfunction

  function automatic logic has_illegal(input logic [BUS_W-1:0] words);
    for (int k = 0; k < NB; k++)
      if (words[k*CFG_W +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  // One complete load. rst_at >= 0 aborts with a reset after that many bits.
  task automatic run_load(input string tag, input logic [BUS_W-1:0] words,
                          input int stall_every, input int stall_len,
                          input int extra_start_at, input logic commit_start,
                          input int rst_at, input logic exp_valid, input logic exp_err);
    int bitn;
    int n;
    start = 1'b1;
    cfg_en = 1'b0;
    tick();
    start = 1'b0;
    chk({tag, "_busy_start"}, 256'(busy), 256'(1));
    chk({tag, "_err_cleared"}, 256'(err), 256'(0));
    bitn = 0;
    for (int k = 0; k < NB; k++) begin
      for (int b = CFG_W - 1; b >= 0; b--) begin
        if (bitn == rst_at) begin
          cfg_en = 1'b0;
          rst = 1'b0;
          #1;
          model_bus = '0;
          model_err = 1'b0;
          exp_cfg_out = 1'b0;
          chk({tag, "_rst_bus"}, 256'(cfg_bus), 256'(0));
          chk({tag, "_rst_busy"}, 256'(busy), 256'(0));
          chk({tag, "_rst_flags"}, 256'({done, err, cfg_valid, cfg_out}), 256'(0));
          tick();
          rst = 1'b1;
          tick();
          chk({tag, "_post_rst_idle"}, 256'({busy, cfg_bus}), 256'(0));
          return;
        end
        cfg_en = 1'b1;
        cfg_in = words[k*CFG_W + b];
        start = (bitn == extra_start_at);
        tick();
        start = 1'b0;
        bitn++;
        if (bitn != NB * CFG_W) begin
          chk({tag, "_cfgout_hold"}, 256'(cfg_out), 256'(exp_cfg_out));
          if (stall_every > 0 && (bitn % stall_every) == 0) begin
            cfg_en = 1'b0;
            repeat (stall_len) begin
              cfg_in = 1'($urandom);
              tick();
            end
            chk({tag, "_stall_busy"}, 256'({busy, done}), 256'(2'b10));
          end
        end
      end
    end
    cfg_en = 1'b0;
    chk({tag, "_early_done"}, 256'({done, cfg_valid, busy}), 256'(3'b001));
    start = commit_start;
    n = 0;
    do begin
      tick();
      start = 1'b0;
      n++;
    end while (done !== 1'b1 && n < 4);
    if (exp_valid) model_bus = words;
    model_err = exp_err;
    chk({tag, "_done_latency"}, 256'(n), 256'(1));
    chk({tag, "_cfg_valid"}, 256'(cfg_valid), 256'(exp_valid));
    chk({tag, "_cfg_bus"}, 256'(cfg_bus), 256'(model_bus));
    chk({tag, "_err"}, 256'(err), 256'(model_err));
    chk({tag, "_busy_end"}, 256'(busy), 256'(0));
    tick();
    chk({tag, "_pulses_end"}, 256'({done, cfg_valid}), 256'(0));
    chk({tag, "_err_sticky"}, 256'(err), 256'(model_err));
  endtask

  typedef struct {
    logic [BUS_W-1:0] words;
    int               stall_every;
    int               stall_len;
    int               extra_start_at;
    int               rst_at;
    logic             exp_valid;
    logic             exp_err;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [BUS_W-1:0] nominal, illegal_w, alt;
    logic [BUS_W-1:0] rw;
    logic [3:0] bp;
    logic ill;

    nominal   = {mk(32'h1, 1'b0, MODE_DUAL), mk(32'hFFFFFFFF, 1'b1, MODE_QUAD),
                 mk(32'h0, 1'b0, MODE_SINGLE), mk(32'h5, 1'b1, MODE_DUAL)};
    illegal_w = {mk(32'h7, 1'b0, MODE_SINGLE), mk(32'h3, 1'b0, MODE_QUAD),
                 mk(32'hABCD, 1'b0, MODE_ILLEGAL), mk(32'h9, 1'b1, MODE_DUAL)};
    alt       = {mk(32'h12345678, 1'b1, MODE_SINGLE), mk(32'h0, 1'b0, MODE_DUAL),
                 mk(32'hDEADBEEF, 1'b1, MODE_QUAD), mk(32'h2, 1'b0, MODE_QUAD)};

    vecs[0] = '{nominal,   0, 0,  -1, -1, 1'b1, 1'b0};
    vecs[1] = '{illegal_w, 0, 0,  -1, -1, 1'b0, 1'b1};
    vecs[2] = '{alt,       0, 0,  -1, -1, 1'b1, 1'b0};
    vecs[3] = '{nominal,   7, 10, 60, -1, 1'b1, 1'b0};
    vecs[4] = '{alt,       0, 0,  -1, 50, 1'b0, 1'b0};
    vecs[5] = '{nominal,   0, 0,  -1, -1, 1'b1, 1'b0};

    // Reset held with inputs toggling.
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom);
      cfg_en = 1'($urandom);
      cfg_in = 1'($urandom);
      tick();
      chk("reset_outputs", 256'({cfg_out, busy, done, err, cfg_valid, cfg_bus}), 256'(0));
    end
    start = 1'b0;
    cfg_en = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("post_reset_bus", 256'(cfg_bus), 256'(0));
    chk("post_reset_busy", 256'(busy), 256'(0));

    // Bypass in IDLE.
    bp = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      cfg_en = 1'b1;
      cfg_in = bp[i];
      tick();
      exp_cfg_out = bp[i];
      chk("bypass", 256'(cfg_out), 256'(exp_cfg_out));
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    tick();
    chk("bypass_hold", 256'(cfg_out), 256'(exp_cfg_out));

    for (int v = 0; v < 6; v++) begin
      run_load($sformatf("vec%0d", v), vecs[v].words, vecs[v].stall_every, vecs[v].stall_len,
               vecs[v].extra_start_at, 1'b0, vecs[v].rst_at, vecs[v].exp_valid, vecs[v].exp_err);
    end
    chk("nominal_slice0", 256'(cfg_bus[CFG_W-1:0]), 256'(35'h2D));
    chk("nominal_slice2", 256'(cfg_bus[2*CFG_W +: CFG_W]), 256'({32'hFFFFFFFF, 3'b110}));

    // Randomized loads against the word-level model.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NB; k++) begin
        logic [1:0] m;
        m = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        rw[k*CFG_W +: CFG_W] = {32'($urandom), 1'($urandom), m};
      end
      ill = has_illegal(rw);
      run_load($sformatf("rnd%0d", r), rw,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 20)) : 0,
               int'($urandom_range(1, 5)), int'($urandom_range(0, BUS_W - 2)),
               1'($urandom), -1, !ill, ill);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
